// File: rtl/conv11_input_buf.sv
// rtl/conv11_input_buf.sv - serial activation stream to IN_CH-wide vector buffer for the 1x1-conv controller
// Optional feature macro: CONV11_IN_LAST_EN (adds s_last for short vectors)
module conv11_input_buf #(
    parameter  int DATA_W = 8,
    parameter  int IN_CH  = 16,
    localparam int CNT_W  = $clog2(IN_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
`ifdef CONV11_IN_LAST_EN
    input  logic                    s_last,
`endif
    output logic                    s_ready,
    input  logic                    input_ready,
    output logic                    input_valid,
    output logic                    inputbuf_load,
    output logic [IN_CH*DATA_W-1:0] buf_data,
    output logic [CNT_W-1:0]        ch_cnt
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_ch_cnt;
    logic [IN_CH*DATA_W-1:0] r_buf;
    logic                    r_load;
    logic                    r_run;
    logic                    w_accept;
    logic                    w_last_word;
    logic                    w_done;
    logic                    w_release;

    // r_run keeps s_ready low until the first clock after reset is released
    always_comb begin
        w_next_state = r_state;
        s_ready      = r_run & (r_state == S_FILL);
        w_accept     = s_valid & s_ready;
        w_last_word  = (r_ch_cnt == CNT_W'(IN_CH - 1));
`ifdef CONV11_IN_LAST_EN
        w_last_word  = w_last_word | s_last;
`endif
        w_done       = w_accept & w_last_word;
        w_release    = (r_state == S_HOLD) & input_ready;
        case (r_state)
            S_FILL:  if (w_done)    w_next_state = S_HOLD;
            S_HOLD:  if (w_release) w_next_state = S_FILL;
            default: w_next_state = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FILL;
            r_ch_cnt <= '0;
            r_buf    <= '0;
            r_load   <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next_state;
            r_load  <= w_done;
            if (w_accept) begin
                for (int k = 0; k < IN_CH; k++) begin
                    if (r_ch_cnt == CNT_W'(k)) begin
                        r_buf[k*DATA_W +: DATA_W] <= s_data;
                    end
                end
                r_ch_cnt <= w_done ? '0 : r_ch_cnt + 1'b1;
            end
            // Release clears the whole vector so short vectors read zero in unused lanes
            if (w_release) begin
                r_buf <= '0;
            end
        end
    end

    assign input_valid   = (r_state == S_HOLD) | (r_ch_cnt != '0);
    assign inputbuf_load = r_load;
    assign buf_data      = r_buf;
    assign ch_cnt        = r_ch_cnt;

endmodule
